// File: rtl/btn_pkg.sv
// Shared types, defaults and helpers for the multi-channel button conditioner.
// Optional auto-repeat is enabled by defining BTN_REPEAT_EN.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRESS = 2'b01,
        ST_HELD  = 2'b10
    } btn_state_e;

    localparam int DEF_DEB_CYCLES   = 4;
    localparam int DEF_REPEAT_DELAY = 50;
    localparam int DEF_REPEAT_RATE  = 10;

    // Width needed to hold values 0..value-1, never less than one bit.
    function automatic int btn_clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-FF synchroniser, tick-based debounce and press FSM.
// Auto-repeat while held is built only when BTN_REPEAT_EN is defined.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tick,
    input  logic       i_btn,
    output btn_state_e o_state
);

    localparam int CNT_W = btn_clog2(DEB_CYCLES + 1);

    logic             r_s1;
    logic             r_s2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1     <= 1'b0;
            r_s2     <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_s1 <= i_btn;
            r_s2 <= r_s1;
            // Any sample agreeing with the stable level restarts the count.
            if (i_tick) begin
                if (r_s2 != r_stable) begin
                    if (r_cnt == CNT_W'(DEB_CYCLES - 1)) begin
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

`ifdef BTN_REPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RPT_W   = btn_clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt;
    logic [RPT_W-1:0] w_rpt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_rpt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rpt   <= w_rpt_nxt;
        end
    end

    // The repeat counter is zero only on the initial press and still 1 on a
    // repeat press, which selects the reload value on the way back to HELD.
    always_comb begin
        w_state_nxt = r_state;
        w_rpt_nxt   = r_rpt;
        case (r_state)
            ST_IDLE: begin
                if (r_stable) w_state_nxt = ST_PRESS;
            end
            ST_PRESS: begin
                if (r_stable) begin
                    w_state_nxt = ST_HELD;
                    w_rpt_nxt   = (r_rpt == '0) ? RPT_W'(REPEAT_DELAY) : RPT_W'(REPEAT_RATE);
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_rpt_nxt   = '0;
                end
            end
            ST_HELD: begin
                if (!r_stable) begin
                    w_state_nxt = ST_IDLE;
                    w_rpt_nxt   = '0;
                end else if (i_tick) begin
                    if (r_rpt == RPT_W'(1)) begin
                        w_state_nxt = ST_PRESS;
                    end else begin
                        w_rpt_nxt = r_rpt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_rpt_nxt   = '0;
            end
        endcase
    end
`else
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (r_stable)  w_state_nxt = ST_PRESS;
            ST_PRESS: w_state_nxt = r_stable ? ST_HELD : ST_IDLE;
            ST_HELD:  if (!r_stable) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end
`endif

    assign o_state = r_state;

endmodule

// File: rtl/button_pulser.sv
// Multi-channel push-button conditioner: one pulse per press plus a held level.
// Define BTN_REPEAT_EN to add auto-repeat pulses while a button stays held.
module button_pulser
    import btn_pkg::*;
#(
    parameter int NUM_BTN      = 5,
    parameter int DEB_CYCLES   = DEF_DEB_CYCLES,
    parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE  = DEF_REPEAT_RATE
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic [NUM_BTN-1:0] btn_in,
    output logic [NUM_BTN-1:0] pulse,
    output logic [NUM_BTN-1:0] held
);

    btn_state_e w_state [NUM_BTN];

    generate
        if (DEB_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
            $error("button_pulser: DEB_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
        end

        for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
            btn_channel #(
                .DEB_CYCLES  (DEB_CYCLES),
                .REPEAT_DELAY(REPEAT_DELAY),
                .REPEAT_RATE (REPEAT_RATE)
            ) u_ch (
                .i_clk  (clk),
                .i_rst  (rst),
                .i_tick (tick),
                .i_btn  (btn_in[g]),
                .o_state(w_state[g])
            );

            // Outputs are forced low while reset is asserted, not just after it.
            assign pulse[g] = (w_state[g] == ST_PRESS) && !rst;
            assign held[g]  = ((w_state[g] == ST_PRESS) || (w_state[g] == ST_HELD)) && !rst;
        end
    endgenerate

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser (NUM_BTN=5, DEB_CYCLES=4, REPEAT_DELAY=5, REPEAT_RATE=2).
// Expected repeat-pulse counts switch on BTN_REPEAT_EN.
module tb_button_pulser;

    localparam int NUM = 5;
    localparam int MAXS = 80;

    logic           clk;
    logic           rst;
    logic           tick;
    logic [NUM-1:0] btn_in;
    logic [NUM-1:0] pulse;
    logic [NUM-1:0] held;

    int n_checks;
    int n_pass;
    int n_fail;

    int hold_len [NUM];
    int drop_at  [NUM];
    int tick_per;
    logic [NUM-1:0] pulse_log [0:MAXS];
    logic [NUM-1:0] held_log  [0:MAXS];

    button_pulser #(
        .NUM_BTN     (NUM),
        .DEB_CYCLES  (4),
        .REPEAT_DELAY(5),
        .REPEAT_RATE (2)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick),
        .btn_in(btn_in),
        .pulse (pulse),
        .held  (held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_vec(input string tag, input logic [NUM-1:0] obs, input logic [NUM-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int c = 0; c < NUM; c++) begin
            hold_len[c] = 0;
            drop_at[c]  = 0;
        end
        tick_per = 1;
    endtask

    // Step s drives the inputs sampled by edge s, then logs the outputs after it.
    task automatic run_window(input int total);
        for (int s = 1; s <= total; s++) begin
            for (int c = 0; c < NUM; c++) begin
                btn_in[c] = (s <= hold_len[c]) && (s != drop_at[c]);
            end
            tick = (tick_per <= 1) || ((s % tick_per) == 0);
            step();
            pulse_log[s] = pulse;
            held_log[s]  = held;
        end
        btn_in = '0;
        tick   = 1'b1;
    endtask

    function automatic int pulse_edge(input int c, input int n, input int total);
        int k;
        k = 0;
        for (int s = 1; s <= total; s++) begin
            if (pulse_log[s][c]) begin
                k++;
                if (k == n) return s;
            end
        end
        return 0;
    endfunction

    function automatic int pulse_cnt(input int c, input int total);
        int k;
        k = 0;
        for (int s = 1; s <= total; s++) begin
            if (pulse_log[s][c]) k++;
        end
        return k;
    endfunction

    function automatic logic [NUM-1:0] activity(input int total);
        logic [NUM-1:0] acc;
        acc = '0;
        for (int s = 1; s <= total; s++) begin
            acc = acc | held_log[s] | pulse_log[s];
        end
        return acc;
    endfunction

    initial begin
        int exp_cnt0, exp_sec0, exp_cnt1, exp_cnt2, exp_cnt3, exp_cnt4;
        logic [NUM-1:0] act;
`ifdef BTN_REPEAT_EN
        exp_cnt0 = 6; exp_sec0 = 13; exp_cnt1 = 5; exp_cnt2 = 4; exp_cnt3 = 3; exp_cnt4 = 9;
`else
        exp_cnt0 = 1; exp_sec0 = 0;  exp_cnt1 = 1; exp_cnt2 = 1; exp_cnt3 = 1; exp_cnt4 = 1;
`endif
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        clear_plan();
        rst    = 1'b1;
        tick   = 1'b1;
        btn_in = '1;

        // Reset held with every button pressed: outputs stay low.
        for (int i = 0; i < 3; i++) begin
            step();
            chk_vec("rst_pulse", pulse, '0);
            chk_vec("rst_held", held, '0);
        end
        rst = 1'b0;

        // All channels pressed through reset release: pulse at edge 7.
        for (int c = 0; c < NUM; c++) hold_len[c] = 8;
        run_window(20);
        chk_vec("all_pulse_e6", pulse_log[6], 5'b00000);
        chk_vec("all_pulse_e7", pulse_log[7], 5'b11111);
        chk_vec("all_pulse_e8", pulse_log[8], 5'b00000);
        chk_vec("all_held_e8", held_log[8], 5'b11111);
        chk_vec("all_held_end", held_log[20], 5'b00000);

        // Clean press on channel 0 for 20 clocks.
        clear_plan();
        hold_len[0] = 20;
        run_window(32);
        act = activity(32);
        chk_int("ch0_first", pulse_edge(0, 1, 32), 7);
        chk_int("ch0_second", pulse_edge(0, 2, 32), exp_sec0);
        chk_int("ch0_count", pulse_cnt(0, 32), exp_cnt0);
        chk_int("ch0_held_e6", int'(held_log[6][0]), 0);
        chk_int("ch0_held_e7", int'(held_log[7][0]), 1);
        chk_int("ch0_held_e24", int'(held_log[24][0]), 1);
        chk_int("ch0_held_end", int'(held_log[32][0]), 0);
        chk_vec("ch0_others", act & 5'b11110, 5'b00000);

        // Bounce on channel 1: 1,1,0 then high; the dip restarts debounce.
        clear_plan();
        hold_len[1] = 20;
        drop_at[1]  = 3;
        run_window(32);
        chk_int("ch1_first", pulse_edge(1, 1, 32), 10);
        chk_int("ch1_count", pulse_cnt(1, 32), exp_cnt1);
        chk_vec("ch1_others", activity(32) & 5'b11101, 5'b00000);

        // Sparse tick every 4th clock on channel 2.
        clear_plan();
        hold_len[2] = 40;
        tick_per    = 4;
        run_window(64);
        chk_int("ch2_first", pulse_edge(2, 1, 64), 17);
        chk_int("ch2_count", pulse_cnt(2, 64), exp_cnt2);
        chk_int("ch2_held_end", int'(held_log[64][2]), 0);

        // Simultaneous press on 3 and 4, channel 3 released early.
        clear_plan();
        hold_len[3] = 12;
        hold_len[4] = 30;
        run_window(44);
        chk_vec("ch34_pulse_e7", pulse_log[7], 5'b11000);
        chk_int("ch3_first", pulse_edge(3, 1, 44), 7);
        chk_int("ch4_first", pulse_edge(4, 1, 44), 7);
        chk_int("ch3_held_e18", int'(held_log[18][3]), 1);
        chk_vec("ch34_held_e19", held_log[19], 5'b10000);
        chk_int("ch3_count", pulse_cnt(3, 44), exp_cnt3);
        chk_int("ch4_count", pulse_cnt(4, 44), exp_cnt4);
        chk_vec("ch34_held_end", held_log[44], 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
